// File: rtl/pong_round_ctrl.sv
// pong_round_ctrl: pong game state machine, score keeping and ball gating
module pong_round_ctrl #(
  parameter logic [3:0] WIN_SCORE   = 4'd7,
  parameter logic [7:0] SERVE_TICKS = 8'd8,
  parameter logic [7:0] POINT_TICKS = 8'd16
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        tick,
  input  logic        start_btn,
  input  logic        miss_top,
  input  logic        miss_bottom,
  output logic        ball_run,
  output logic        ball_load,
  output logic        serve_side,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [13:0] score_disp,
  output logic [1:0]  winner,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, RALLY = 3'd2, PAUSE = 3'd3, POINT = 3'd4, OVER = 3'd5} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_sync;
  logic [7:0]  r_cnt;
  logic [3:0]  r_s1, r_s2, w_s1, w_s2;
  logic [1:0]  r_win, w_win;
  logic        r_side, w_side, r_load, w_start;
  logic [13:0] r_disp;
  assign w_start    = r_sync[1] & ~r_sync[2];
  assign ball_run   = (r_state == RALLY);
  assign ball_load  = r_load;
  assign serve_side = r_side;
  assign score1     = r_s1;
  assign score2     = r_s2;
  assign score_disp = r_disp;
  assign winner     = r_win;
  assign state      = r_state;
  // next state plus the score/winner/serve-side values to commit on this edge
  always_comb begin
    w_next = r_state;
    w_s1   = r_s1;
    w_s2   = r_s2;
    w_win  = r_win;
    w_side = r_side;
    case (r_state)
      IDLE:  if (w_start) w_next = SERVE;
      SERVE: if (tick && r_cnt == SERVE_TICKS - 8'd1) w_next = RALLY;
      RALLY: begin
        if (miss_top) begin
          w_s1   = r_s1 + 4'd1;
          w_side = 1'b1;
          w_next = (w_s1 == WIN_SCORE) ? OVER : POINT;
          w_win  = (w_s1 == WIN_SCORE) ? 2'b01 : r_win;
        end else if (miss_bottom) begin
          w_s2   = r_s2 + 4'd1;
          w_side = 1'b0;
          w_next = (w_s2 == WIN_SCORE) ? OVER : POINT;
          w_win  = (w_s2 == WIN_SCORE) ? 2'b10 : r_win;
        end else if (w_start) w_next = PAUSE;
      end
      PAUSE: if (w_start) w_next = RALLY;
      POINT: if (tick && r_cnt == POINT_TICKS - 8'd1) w_next = SERVE;
      OVER: begin
        if (w_start) begin
          w_next = SERVE;
          w_s1   = 4'd0;
          w_s2   = 4'd0;
          w_win  = 2'b00;
          w_side = 1'b0;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  // state, scores, button synchronizer, tick counter and display register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_sync  <= 3'd0;
      r_cnt   <= 8'd0;
      r_s1    <= 4'd0;
      r_s2    <= 4'd0;
      r_win   <= 2'b00;
      r_side  <= 1'b0;
      r_load  <= 1'b0;
      r_disp  <= 14'd0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[1:0], start_btn};
      r_cnt   <= (w_next != r_state) ? 8'd0 : (tick ? r_cnt + 8'd1 : r_cnt);
      r_s1    <= w_s1;
      r_s2    <= w_s2;
      r_win   <= w_win;
      r_side  <= w_side;
      r_load  <= (w_next == SERVE) && (r_state != SERVE);
      r_disp  <= {10'd0, r_s1} * 14'd100 + {10'd0, r_s2};
    end
  end
endmodule

// File: tb/tb_pong_round_ctrl.sv
// tb_pong_round_ctrl: scoreboard bench with a behavioural game model
module tb_pong_round_ctrl;
  localparam int WIN = 7, SRV = 8, PNT = 16;
  localparam int P_IDLE = 0, P_SERVE = 1, P_RALLY = 2, P_PAUSE = 3, P_POINT = 4, P_OVER = 5;
  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  s1, s2;
    logic [13:0] disp;
    logic [1:0]  win;
    logic        side, load, run;
  } snap_t;
  logic CLK = 0, RSTn = 1, tick = 0, start_btn = 0, miss_top = 0, miss_bottom = 0;
  logic ball_run, ball_load, serve_side;
  logic [3:0] score1, score2;
  logic [13:0] score_disp;
  logic [1:0] winner;
  logic [2:0] state;
  int checks = 0, errors = 0;
  snap_t q[$];
  pong_round_ctrl #(.WIN_SCORE(4'(WIN)), .SERVE_TICKS(8'(SRV)), .POINT_TICKS(8'(PNT))) dut (
    .CLK(CLK), .RSTn(RSTn), .tick(tick), .start_btn(start_btn), .miss_top(miss_top),
    .miss_bottom(miss_bottom), .ball_run(ball_run), .ball_load(ball_load), .serve_side(serve_side),
    .score1(score1), .score2(score2), .score_disp(score_disp), .winner(winner), .state(state));
  always #5 CLK = ~CLK;
  // game model: phase number, remaining ticks in timed phases, button sample history
  int m_phase = 0, m_prev = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_side = 0, m_rem = 0, m_disp = 0;
  bit m_ld = 0, m_press = 0;
  bit m_hist [3] = '{0, 0, 0};
  function automatic snap_t mk();
    snap_t s;
    s.st = 3'(m_phase); s.s1 = 4'(m_s1); s.s2 = 4'(m_s2); s.disp = 14'(m_disp);
    s.win = 2'(m_win); s.side = 1'(m_side); s.load = m_ld; s.run = (m_phase == P_RALLY);
    return s;
  endfunction
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_side = 0; m_rem = 0; m_disp = 0; m_ld = 0;
      m_hist = '{0, 0, 0};
      q.delete();
      q.push_back(mk());
    end else begin
      m_press = m_hist[1] && !m_hist[2];
      m_prev = m_phase;
      m_disp = m_s1 * 100 + m_s2;
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = start_btn;
      case (m_phase)
        P_IDLE: if (m_press) begin m_phase = P_SERVE; m_rem = SRV; end
        P_SERVE: if (tick) begin m_rem--; if (m_rem == 0) m_phase = P_RALLY; end
        P_RALLY:
          if (miss_top) begin
            m_s1++; m_side = 1;
            if (m_s1 == WIN) begin m_phase = P_OVER; m_win = 1; end
            else begin m_phase = P_POINT; m_rem = PNT; end
          end else if (miss_bottom) begin
            m_s2++; m_side = 0;
            if (m_s2 == WIN) begin m_phase = P_OVER; m_win = 2; end
            else begin m_phase = P_POINT; m_rem = PNT; end
          end else if (m_press) m_phase = P_PAUSE;
        P_PAUSE: if (m_press) m_phase = P_RALLY;
        P_POINT: if (tick) begin m_rem--; if (m_rem == 0) begin m_phase = P_SERVE; m_rem = SRV; end end
        P_OVER: if (m_press) begin m_s1 = 0; m_s2 = 0; m_win = 0; m_side = 0; m_phase = P_SERVE; m_rem = SRV; end
        default: m_phase = P_IDLE;
      endcase
      m_ld = (m_phase == P_SERVE) && (m_prev != P_SERVE);
      q.push_back(mk());
    end
  end
  // monitor: every falling edge the DUT presents a full output set to compare
  always @(negedge CLK) begin
    snap_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{st: state, s1: score1, s2: score2, disp: score_disp, win: winner, side: serve_side, load: ball_load, run: ball_run};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got st=%0d s1=%0d s2=%0d disp=%0d win=%0d side=%0d load=%0d run=%0d, want st=%0d s1=%0d s2=%0d disp=%0d win=%0d side=%0d load=%0d run=%0d",
          $time, a.st, a.s1, a.s2, a.disp, a.win, a.side, a.load, a.run, e.st, e.s1, e.s2, e.disp, e.win, e.side, e.load, e.run);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic press();
    start_btn = 1; cyc(4); start_btn = 0; cyc(4);
  endtask
  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 400; i++) begin
      if (state == s) return;
      @(negedge CLK);
    end
    checks++; errors++;
    $display("FAIL wait_state: got state=%0d want %0d within 400 cycles", state, s);
  endtask
  task automatic pulse_miss(input logic t, input logic b);
    miss_top = t; miss_bottom = b; cyc(1); miss_top = 0; miss_bottom = 0;
  endtask
  task automatic async_reset_check();
    #2 RSTn = 0;
    #1 checks++;
    if ({state, ball_load, ball_run, serve_side, score1, score2, winner, score_disp} !== '0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d load=%0d run=%0d side=%0d s1=%0d s2=%0d win=%0d disp=%0d, want all zero",
        state, ball_load, ball_run, serve_side, score1, score2, winner, score_disp);
    end
    cyc(2);
    #3 RSTn = 1;
  endtask
  initial begin
    #1 RSTn = 0;
    cyc(3);
    #2 RSTn = 1;
    cyc(2);
    tick = 1;
    press();
    wait_state(3'(P_RALLY));
    cyc(2);
    pulse_miss(1, 0);
    wait_state(3'(P_SERVE));
    wait_state(3'(P_RALLY));
    pulse_miss(1, 1);
    miss_bottom = 1;
    wait_state(3'(P_SERVE));
    wait_state(3'(P_RALLY));
    miss_bottom = 0;
    for (int k = 0; k < WIN; k++) begin
      wait_state(3'(P_RALLY));
      cyc(1);
      pulse_miss(0, 1);
    end
    wait_state(3'(P_OVER));
    cyc(3);
    press();
    wait_state(3'(P_RALLY));
    press();
    wait_state(3'(P_PAUSE));
    pulse_miss(0, 1);
    cyc(2);
    press();
    wait_state(3'(P_RALLY));
    pulse_miss(1, 0);
    wait_state(3'(P_SERVE));
    cyc(2);
    async_reset_check();
    cyc(5);
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      tick = (i % 700 < 60) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      miss_top = 1'($urandom_range(0, 11) == 0);
      miss_bottom = 1'($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 1499) == 0) async_reset_check();
    end
    tick = 0; miss_top = 0; miss_bottom = 0; start_btn = 0;
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
